// File: rtl/ysyx_23060240_bus_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
// Holds the FSM state encoding, the master IDs used by the grant registers,
// the default response timeout and the packed type for a latched request.
package ysyx_23060240_bus_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Master IDs
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  // WAIT cycles without a memory response before an error response
  localparam int unsigned TIMEOUT_DEFAULT = 1023;

  // Request fields captured on acceptance and replayed to memory
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
  } req_t;

endpackage

// File: rtl/ysyx_23060240_rr_arb.sv
// Two-way round-robin choice between the IFU and LSU request valids.
// Ports:
//   ifu_valid_i  - IFU request pending
//   lsu_valid_i  - LSU request pending
//   last_grant_i - master granted most recently (MST_IFU / MST_LSU)
//   winner_o     - selected master; only meaningful when a valid is high
module ysyx_23060240_rr_arb
  import ysyx_23060240_bus_pkg::*;
(
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  input  logic last_grant_i,
  output logic winner_o
);

  always_comb begin
    winner_o = MST_IFU;
    if (ifu_valid_i && lsu_valid_i) begin
      // On a tie the master that was not served last wins.
      winner_o = (last_grant_i == MST_IFU) ? MST_LSU : MST_IFU;
    end else if (lsu_valid_i) begin
      winner_o = MST_LSU;
    end
  end

endmodule

// File: rtl/ysyx_23060240_mem_arb.sv
// Memory arbiter: serialises IFU and LSU requests onto one memory port,
// one transaction outstanding at a time, with a response timeout.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   ifu_req_*/ifu_addr           - fetch request handshake and address
//   ifu_resp_*/ifu_rdata         - fetch response handshake, data, timeout flag
//   lsu_req_*/lsu_addr/wdata/wen/wmask - load/store request
//   lsu_resp_*/lsu_rdata         - load/store response
//   mem_req_*/mem_addr/wdata/wen/wmask - downstream request
//   mem_resp_*/mem_rdata         - downstream response
module ysyx_23060240_mem_arb
  import ysyx_23060240_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        lsu_wen,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic winner;
  logic accept;
  logic resp_ready_sel;

  ysyx_23060240_rr_arb u_rr_arb (
    .ifu_valid_i  (ifu_req_valid),
    .lsu_valid_i  (lsu_req_valid),
    .last_grant_i (last_grant_q),
    .winner_o     (winner)
  );

  assign accept = (state_q == ST_IDLE) && (ifu_req_valid || lsu_req_valid);

  assign ifu_req_ready = accept && (winner == MST_IFU);
  assign lsu_req_ready = accept && (winner == MST_LSU);

  // Ready in IDLE as well, so a late response after a timeout is drained.
  assign mem_resp_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = req_q.addr;
  assign mem_wdata     = req_q.wdata;
  assign mem_wen       = req_q.wen;
  assign mem_wmask     = req_q.wmask;

  assign ifu_resp_valid = (state_q == ST_RESP) && (grant_q == MST_IFU);
  assign lsu_resp_valid = (state_q == ST_RESP) && (grant_q == MST_LSU);
  assign ifu_rdata      = rdata_q;
  assign lsu_rdata      = rdata_q;
  assign ifu_resp_err   = err_q;
  assign lsu_resp_err   = err_q;

  assign resp_ready_sel = (grant_q == MST_IFU) ? ifu_resp_ready : lsu_resp_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grant_d      = winner;
          last_grant_d = winner;
          if (winner == MST_IFU) begin
            req_d.addr  = ifu_addr;
            req_d.wdata = '0;
            req_d.wmask = '0;
            req_d.wen   = 1'b0;
          end else begin
            req_d.addr  = lsu_addr;
            req_d.wdata = lsu_wdata;
            req_d.wmask = lsu_wmask;
            req_d.wen   = lsu_wen;
          end
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response in the last counted cycle still wins over the timeout.
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready_sel) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= MST_IFU;
      last_grant_q <= MST_LSU;
      req_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: doc/ysyx_23060240_mem_arb.md
YSYX_23060240_MEM_ARB -- requirements
Module: ysyx_23060240_mem_arb

Interface
REQ-001 Parameter: TIMEOUT, default 1023, number of WAIT cycles without mem_resp_valid before an error response is returned.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ifu_req_valid  input  1  instruction-fetch request valid.
REQ-005 ifu_req_ready  output  1  request accepted this cycle.
REQ-006 ifu_addr  input  32  fetch address.
REQ-007 ifu_resp_valid  output  1  fetch response valid.
REQ-008 ifu_resp_ready  input  1  IFU accepts the response.
REQ-009 ifu_rdata  output  32  fetched word.
REQ-010 ifu_resp_err  output  1  response produced by timeout.
REQ-011 lsu_req_valid / lsu_req_ready  input / output  1 / 1  load-store request handshake.
REQ-012 lsu_addr, lsu_wdata  input  32 each  address and store data.
REQ-013 lsu_wen  input  1  1 = store, 0 = load; lsu_wmask  input  4  byte strobes.
REQ-014 lsu_resp_valid, lsu_resp_ready, lsu_rdata, lsu_resp_err: same meaning as the IFU response ports.
REQ-015 mem_req_valid  output  1  / mem_req_ready  input  1  downstream request handshake.
REQ-016 mem_addr, mem_wdata  output  32 each; mem_wen  output  1; mem_wmask  output  4.
REQ-017 mem_resp_valid  input  1 / mem_resp_ready  output  1 / mem_rdata  input  32  downstream response handshake.

Function
REQ-018 One transaction is outstanding at a time; the FSM states are IDLE, REQ, WAIT and RESP.
REQ-019 IDLE: if exactly one *_req_valid is high, that master wins; if both are high, the master not granted last wins (round-robin).
REQ-020 IDLE: the winner's *_req_ready is asserted combinationally in the same cycle; the loser's ready stays 0.
REQ-021 Acceptance latches addr, wen, wdata and wmask (the IFU forces wen=0, wmask=0), sets the grant and last_grant registers, and moves to REQ.
REQ-022 REQ: mem_req_valid=1 with the latched fields held stable; on mem_req_ready=1, move to WAIT.
REQ-023 WAIT: mem_resp_ready=1; on mem_resp_valid=1, latch mem_rdata, set err=0 and move to RESP.
REQ-024 WAIT: a 16-bit counter increments each cycle; when it reaches TIMEOUT-1 without mem_resp_valid, latch rdata=32'h0, set err=1 and move to RESP.
REQ-025 The counter clears on entry to WAIT.
REQ-026 RESP: only the granted master's *_resp_valid=1, driven with the latched rdata/err; on its *_resp_ready, move to IDLE.
REQ-027 IDLE: mem_resp_ready=1 and any stray mem_resp_valid (a late response after a timeout) is discarded.
REQ-028 mem_resp_ready=0 in REQ and RESP.
REQ-029 A request arriving in REQ, WAIT or RESP sees ready=0 and must hold valid.
REQ-030 An arrival in the RESP-to-IDLE cycle is accepted no earlier than the following IDLE cycle.
REQ-031 Minimum latency: accept at cycle N, mem_req_valid at N+1, response to the master at N+3 (zero-wait memory).
REQ-032 A master's *_req_valid dropping after acceptance has no effect on the in-flight transaction.
REQ-033 All outputs other than the combinational req_ready and mem_resp_ready are registered or decoded from state.

Reset
REQ-034 When rst=1 at posedge clk: state=IDLE, counter=0, last_grant=LSU (so the IFU wins the first tie), latched fields and rdata=0, err=0.
REQ-035 Reset mid-transaction aborts it: no response is delivered, and all *_resp_valid and mem_req_valid are 0 from the next cycle.

Structure
REQ-036 Package ysyx_23060240_bus_pkg holds the state encoding, master IDs (IFU=0, LSU=1) and the TIMEOUT default.
REQ-037 The 2-way round-robin choice is sub-module ysyx_23060240_rr_arb (inputs: two valids, last_grant; output: winner); all else lives in the top.

Verification
REQ-038 IFU-only read: ifu_addr=0x80000000, zero-wait memory returning 0x00000413 -> ifu_resp_valid at cycle +3 with rdata 0x00000413 and err=0.
REQ-039 Simultaneous IFU and LSU requests just after reset -> IFU is granted first and LSU second; a second simultaneous pair goes IFU then LSU again, alternating by last_grant.
REQ-040 LSU store: addr=0x80001000, wdata=0xDEADBEEF, wmask=4'b0011 -> mem_wen=1 with the fields stable while mem_req_ready is held low for 5 cycles.
REQ-041 Memory never responds, TIMEOUT=8 -> lsu_resp_valid with err=1 and rdata=0 after 8 WAIT cycles; a late mem_resp_valid is dropped in IDLE.
REQ-042 Backpressure and reset: ifu_resp_ready=0 for 4 cycles holds the response and blocks a pending LSU request; rst asserted in WAIT -> IDLE the next cycle with no response.
